// File: rtl/iteration_controller_if.sv
// Request/acknowledge channel between the iteration sequencer and the external update unit.
interface iteration_controller_if #(parameter int WIDTH = 8);
    logic             upd_req;
    logic [WIDTH-1:0] upd_old;
    logic             upd_ack;
    logic [WIDTH-1:0] upd_new;

    modport master (output upd_req, output upd_old, input upd_ack, input upd_new);
    modport slave  (input upd_req, input upd_old, output upd_ack, output upd_new);
endinterface

// File: rtl/iteration_controller.sv
// Iterative solver sequencer: drives the update unit, tracks |new-old| against a tolerance,
// and finishes on CONSEC consecutive sub-tolerance deltas or after max_iter iterations.
module iteration_controller #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 8,
    parameter int CONSEC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [WIDTH-1:0]     init_val_i,
    input  logic [WIDTH-1:0]     err_tol_i,
    input  logic [ITER_W-1:0]    max_iter_i,
    iteration_controller_if.master upd,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 converged_o,
    output logic                 timeout_o,
    output logic [WIDTH-1:0]     result_o,
    output logic [ITER_W-1:0]    iter_count_o,
    output logic [WIDTH-1:0]     delta_o
);
    localparam int CW = $clog2(CONSEC + 1);
    localparam logic [CW-1:0] CONSEC_C = CW'(CONSEC);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CHECK, S_DONE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  old_q, new_q, tol_q, result_q, delta_q;
    logic [ITER_W-1:0] max_q, iter_q;
    logic [CW-1:0]     consec_q;
    logic              req_q, busy_q, done_q, conv_q, tout_q;
    logic [WIDTH-1:0]  delta_d;
    logic [CW-1:0]     consec_d;

    // Delta is an exact unsigned distance; the streak saturates so it can never wrap past CONSEC.
    always_comb begin
        delta_d  = (new_q >= old_q) ? (new_q - old_q) : (old_q - new_q);
        consec_d = '0;
        if (delta_d < tol_q) begin
            consec_d = (consec_q == CONSEC_C) ? consec_q : consec_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            old_q    <= '0;
            new_q    <= '0;
            tol_q    <= '0;
            max_q    <= '0;
            iter_q   <= '0;
            consec_q <= '0;
            result_q <= '0;
            delta_q  <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            conv_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        old_q    <= init_val_i;
                        new_q    <= init_val_i;
                        tol_q    <= err_tol_i;
                        max_q    <= max_iter_i;
                        iter_q   <= '0;
                        consec_q <= '0;
                        delta_q  <= '0;
                        result_q <= '0;
                        conv_q   <= 1'b0;
                        tout_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        if (max_iter_i == '0) begin
                            tout_q   <= 1'b1;
                            result_q <= init_val_i;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (abort_i) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        conv_q  <= 1'b0;
                        tout_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (upd.upd_ack) begin
                        new_q   <= upd.upd_new;
                        iter_q  <= iter_q + ITER_W'(1);
                        req_q   <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        conv_q  <= 1'b0;
                        tout_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        delta_q  <= delta_d;
                        consec_q <= consec_d;
                        // Convergence wins over timeout when both land on the same iteration.
                        if (consec_d == CONSEC_C) begin
                            conv_q   <= 1'b1;
                            result_q <= new_q;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (iter_q == max_q) begin
                            tout_q   <= 1'b1;
                            result_q <= new_q;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            old_q   <= new_q;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign upd.upd_req  = req_q;
    assign upd.upd_old  = old_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign converged_o  = conv_q;
    assign timeout_o    = tout_q;
    assign result_o     = result_q;
    assign iter_count_o = iter_q;
    assign delta_o      = delta_q;
endmodule

// File: tb/tb_iteration_controller.sv
// Directed bench for iteration_controller: convergence, timeout, abs delta, priority, stalls, abort, reset.
module tb_iteration_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, abort_i;
    logic [7:0] init_val_i, err_tol_i, max_iter_i;
    logic       busy_o, done_o, converged_o, timeout_o;
    logic [7:0] result_o, iter_count_o, delta_o;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    iteration_controller_if #(.WIDTH(8)) upd_if ();

    iteration_controller #(.WIDTH(8), .ITER_W(8), .CONSEC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .init_val_i(init_val_i), .err_tol_i(err_tol_i), .max_iter_i(max_iter_i),
        .upd(upd_if), .busy_o(busy_o), .done_o(done_o), .converged_o(converged_o),
        .timeout_o(timeout_o), .result_o(result_o), .iter_count_o(iter_count_o), .delta_o(delta_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_start(input logic [7:0] init, input logic [7:0] tol, input logic [7:0] mx, output int s);
        init_val_i = init; err_tol_i = tol; max_iter_i = mx; start_i = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Update-unit model: waits for a request, holds off for 'stall' cycles, then acks with v.
    task automatic serve(input logic [7:0] v, input int stall, output bit ok);
        int n;
        logic [7:0] old0;
        ok = 1'b1; n = 0;
        while (upd_if.upd_req !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (upd_if.upd_req !== 1'b1) begin ok = 1'b0; return; end
        old0 = upd_if.upd_old;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (upd_if.upd_req !== 1'b1 || upd_if.upd_old !== old0) ok = 1'b0;
        end
        upd_if.upd_ack = 1'b1; upd_if.upd_new = v;
        @(posedge clk); #1;
        upd_if.upd_ack = 1'b0;
        if (upd_if.upd_req !== 1'b0) ok = 1'b0;
    endtask

    task automatic wait_done(input int s, output int dt);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        dt = (done_o === 1'b1) ? (cyc - s) : -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_i = 0; abort_i = 0; init_val_i = 0; err_tol_i = 0; max_iter_i = 0;
        upd_if.upd_ack = 0; upd_if.upd_new = 0;
        #12;
        checks++; if ({busy_o, done_o, converged_o, timeout_o, upd_if.upd_req} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {busy_o, done_o, converged_o, timeout_o, upd_if.upd_req}); end
        checks++; if ({result_o, iter_count_o, delta_o, upd_if.upd_old} !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {result_o, iter_count_o, delta_o, upd_if.upd_old}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int s, dt; bit ok, all_ok;
        all_ok = 1;
        do_start(8'd100, 8'd3, 8'd10, s);
        checks++; if (upd_if.upd_req !== 1'b1 || upd_if.upd_old !== 8'd100) begin
            errors++; $display("FAIL basic_first_req got req=%b old=%0d exp req=1 old=100", upd_if.upd_req, upd_if.upd_old); end
        serve(8'd80, 0, ok); all_ok &= ok;
        serve(8'd81, 0, ok); all_ok &= ok;
        serve(8'd82, 0, ok); all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("FAIL basic_handshake got 0 exp 1"); end
        wait_done(s, dt);
        checks++; if (dt != 7) begin errors++; $display("FAIL basic_latency got %0d exp 7", dt); end
        checks++; if (converged_o !== 1'b1 || timeout_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL basic_flags got conv=%b to=%b busy=%b exp 1 0 1", converged_o, timeout_o, busy_o); end
        @(posedge clk); #1;
        checks++; if (result_o !== 8'd82) begin errors++; $display("FAIL basic_result got %0d exp 82", result_o); end
        checks++; if (iter_count_o !== 8'd3) begin errors++; $display("FAIL basic_iter got %0d exp 3", iter_count_o); end
        checks++; if (delta_o !== 8'd1) begin errors++; $display("FAIL basic_delta got %0d exp 1", delta_o); end
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || converged_o !== 1'b1) begin
            errors++; $display("FAIL basic_after got done=%b busy=%b conv=%b exp 0 0 1", done_o, busy_o, converged_o); end
    endtask

    task automatic test_timeout;
        int s, dt; bit ok, all_ok;
        all_ok = 1;
        do_start(8'd0, 8'd3, 8'd4, s);
        serve(8'd255, 0, ok); all_ok &= ok;
        serve(8'd0,   0, ok); all_ok &= ok;
        serve(8'd255, 0, ok); all_ok &= ok;
        serve(8'd0,   0, ok); all_ok &= ok;
        wait_done(s, dt);
        checks++; if (!all_ok || dt < 0) begin errors++; $display("FAIL timeout_run got ok=%0d dt=%0d exp ok=1 dt>=0", all_ok, dt); end
        @(posedge clk); #1;
        checks++; if (timeout_o !== 1'b1 || converged_o !== 1'b0) begin
            errors++; $display("FAIL timeout_flags got to=%b conv=%b exp 1 0", timeout_o, converged_o); end
        checks++; if (iter_count_o !== 8'd4 || delta_o !== 8'd255 || result_o !== 8'd0) begin
            errors++; $display("FAIL timeout_data got iter=%0d delta=%0d res=%0d exp 4 255 0", iter_count_o, delta_o, result_o); end
    endtask

    task automatic test_abs;
        int s, dt; bit ok, all_ok;
        all_ok = 1;
        do_start(8'd5, 8'd246, 8'd2, s);
        serve(8'd250, 0, ok); all_ok &= ok;
        @(posedge clk); #1;
        checks++; if (delta_o !== 8'd245) begin errors++; $display("FAIL abs_up got %0d exp 245", delta_o); end
        serve(8'd5, 0, ok); all_ok &= ok;
        wait_done(s, dt);
        checks++; if (!all_ok || dt < 0) begin errors++; $display("FAIL abs_run got ok=%0d dt=%0d exp ok=1 dt>=0", all_ok, dt); end
        @(posedge clk); #1;
        checks++; if (delta_o !== 8'd245 || converged_o !== 1'b1 || result_o !== 8'd5) begin
            errors++; $display("FAIL abs_down got delta=%0d conv=%b res=%0d exp 245 1 5", delta_o, converged_o, result_o); end
    endtask

    task automatic test_priority;
        int s, dt; bit ok;
        // deltas 1,1 with max=3: converge at iteration 2
        do_start(8'd10, 8'd2, 8'd3, s);
        serve(8'd11, 0, ok); serve(8'd12, 0, ok);
        wait_done(s, dt); @(posedge clk); #1;
        checks++; if (converged_o !== 1'b1 || timeout_o !== 1'b0 || iter_count_o !== 8'd2) begin
            errors++; $display("FAIL prio_conv got conv=%b to=%b iter=%0d exp 1 0 2", converged_o, timeout_o, iter_count_o); end
        // deltas 1,9,1 with max=3: streak broken, timeout
        do_start(8'd10, 8'd2, 8'd3, s);
        serve(8'd11, 0, ok); serve(8'd20, 0, ok); serve(8'd21, 0, ok);
        wait_done(s, dt); @(posedge clk); #1;
        checks++; if (converged_o !== 1'b0 || timeout_o !== 1'b1 || iter_count_o !== 8'd3 || delta_o !== 8'd1) begin
            errors++; $display("FAIL prio_streak got conv=%b to=%b iter=%0d delta=%0d exp 0 1 3 1", converged_o, timeout_o, iter_count_o, delta_o); end
        // deltas 1,1 with max=2: convergence and limit coincide
        do_start(8'd10, 8'd2, 8'd2, s);
        serve(8'd11, 0, ok); serve(8'd12, 0, ok);
        wait_done(s, dt); @(posedge clk); #1;
        checks++; if (converged_o !== 1'b1 || timeout_o !== 1'b0 || result_o !== 8'd12) begin
            errors++; $display("FAIL prio_same got conv=%b to=%b res=%0d exp 1 0 12", converged_o, timeout_o, result_o); end
    endtask

    task automatic test_stall;
        int s, dt; bit ok;
        do_start(8'd50, 8'd5, 8'd2, s);
        start_i = 1'b1; init_val_i = 8'd0; max_iter_i = 8'd0;
        serve(8'd52, 5, ok);
        start_i = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_stable got 0 exp 1"); end
        upd_if.upd_ack = 1'b1; upd_if.upd_new = 8'd200;
        @(posedge clk); #1;
        upd_if.upd_ack = 1'b0;
        checks++; if (iter_count_o !== 8'd1 || upd_if.upd_old !== 8'd52 || upd_if.upd_req !== 1'b1) begin
            errors++; $display("FAIL stall_spurious got iter=%0d old=%0d req=%b exp 1 52 1", iter_count_o, upd_if.upd_old, upd_if.upd_req); end
        serve(8'd53, 0, ok);
        wait_done(s, dt);
        start_i = 1'b1; max_iter_i = 8'd0; init_val_i = 8'd9;
        @(posedge clk); #1;
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 8'd53 || converged_o !== 1'b1) begin
            errors++; $display("FAIL stall_start_in_done got busy=%b done=%b res=%0d conv=%b exp 0 0 53 1", busy_o, done_o, result_o, converged_o); end
        upd_if.upd_ack = 1'b1; upd_if.upd_new = 8'd1;
        @(posedge clk); #1;
        upd_if.upd_ack = 1'b0;
        checks++; if (busy_o !== 1'b0 || iter_count_o !== 8'd2 || upd_if.upd_req !== 1'b0) begin
            errors++; $display("FAIL stall_idle_ack got busy=%b iter=%0d req=%b exp 0 2 0", busy_o, iter_count_o, upd_if.upd_req); end
    endtask

    task automatic test_abort;
        int s; bit seen;
        do_start(8'd10, 8'd2, 8'd5, s);
        abort_i = 1'b1; upd_if.upd_ack = 1'b1; upd_if.upd_new = 8'd11;
        @(posedge clk); #1;
        abort_i = 1'b0; upd_if.upd_ack = 1'b0;
        checks++; if (busy_o !== 1'b0 || upd_if.upd_req !== 1'b0 || iter_count_o !== 8'd0) begin
            errors++; $display("FAIL abort_req got busy=%b req=%b iter=%0d exp 0 0 0", busy_o, upd_if.upd_req, iter_count_o); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done_o === 1'b1) seen = 1;
            @(posedge clk); #1;
        end
        checks++; if (seen || converged_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL abort_nodone got done_seen=%0d conv=%b to=%b exp 0 0 0", seen, converged_o, timeout_o); end
    endtask

    task automatic test_reset_mid;
        int s; bit ok;
        do_start(8'd10, 8'd2, 8'd5, s);
        serve(8'd30, 0, ok);
        serve(8'd31, 0, ok);
        checks++; if (iter_count_o !== 8'd2 || delta_o !== 8'd20 || upd_if.upd_old !== 8'd30) begin
            errors++; $display("FAIL rstmid_pre got iter=%0d delta=%0d old=%0d exp 2 20 30", iter_count_o, delta_o, upd_if.upd_old); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({busy_o, done_o, converged_o, timeout_o, upd_if.upd_req} !== 5'b0 ||
                      {result_o, iter_count_o, delta_o, upd_if.upd_old} !== 32'h0) begin
            errors++; $display("FAIL rstmid_async got flags=%b data=%h exp 0 0",
                               {busy_o, done_o, converged_o, timeout_o, upd_if.upd_req},
                               {result_o, iter_count_o, delta_o, upd_if.upd_old}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_max_zero;
        int s;
        do_start(8'd77, 8'd3, 8'd0, s);
        checks++; if (done_o !== 1'b1 || timeout_o !== 1'b1 || converged_o !== 1'b0 || result_o !== 8'd77 || upd_if.upd_req !== 1'b0) begin
            errors++; $display("FAIL maxzero got done=%b to=%b conv=%b res=%0d req=%b exp 1 1 0 77 0",
                               done_o, timeout_o, converged_o, result_o, upd_if.upd_req); end
        @(posedge clk); #1;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b1) begin
            errors++; $display("FAIL maxzero_after got busy=%b done=%b to=%b exp 0 0 1", busy_o, done_o, timeout_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_abs();
        test_priority();
        test_stall();
        test_abort();
        test_reset_mid();
        test_max_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/iteration_controller.md
Name: iteration_controller

Overview:
Sequencer for an iterative fixed-point solver that wraps a convergence check. It hands the current estimate to an external update unit over a req/ack handshake and captures the new estimate. It computes |new - old| and declares convergence after CONSEC consecutive sub-tolerance deltas, or times out after max_iter iterations. It sits between the top-level command interface and the physics update datapath.

Parameters:
WIDTH, 8, data/estimate width (unsigned)
ITER_W, 8, iteration counter width
CONSEC, 2, consecutive sub-tolerance deltas required to declare convergence (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin solve; sampled only in IDLE
abort  input  1  synchronous cancel; effective in REQ/CHECK
init_val  input  WIDTH  initial estimate, latched on start
err_tol  input  WIDTH  tolerance, latched on start; converge when delta < tol
max_iter  input  ITER_W  iteration limit, latched on start
upd_req  output  1  request to update unit
upd_old  output  WIDTH  current estimate, stable while upd_req=1
upd_ack  input  1  update unit accepts and returns upd_new this cycle
upd_new  input  WIDTH  new estimate, valid when upd_ack=1
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at completion
converged  output  1  sticky result flag
timeout  output  1  sticky result flag
result  output  WIDTH  final estimate
iter_count  output  ITER_W  iterations completed
delta  output  WIDTH  most recent |new - old|

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal old/new/consec registers 0. Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, REQ, CHECK, DONE.
- IDLE: start=1 latches init_val into old_reg, and latches err_tol and max_iter. It clears converged, timeout, iter_count, delta, result and consec, then goes to REQ. Exception: max_iter=0 goes to DONE with timeout=1 and result=init_val.
- REQ: upd_req=1; upd_old=old_reg. If upd_ack=1 this cycle: new_reg<=upd_new, iter_count++, go to CHECK. upd_req is 0 in the following cycle. upd_ack is ignored outside REQ.
- CHECK (exactly 1 cycle), upd_req=0:
  - delta <= (new_reg>=old_reg) ? new_reg-old_reg : old_reg-new_reg. Unsigned and exact; no wrap or sign interpretation.
  - If delta < tol, consec++ (saturating at CONSEC); otherwise consec=0.
  - If the updated consec == CONSEC: go to DONE with converged=1.
  - Else if iter_count == max_iter: go to DONE with timeout=1.
  - Else old_reg<=new_reg and go to REQ.
  - Convergence takes priority over timeout on the same iteration.
- DONE (1 cycle): done=1; result<=new_reg (init_val for the max_iter=0 case); busy=1; go to IDLE. converged, timeout, result, iter_count and delta hold until the next accepted start.
- abort=1 in REQ or CHECK: go to IDLE next cycle. upd_req=0, no done pulse, converged=timeout=0. abort in IDLE or DONE is ignored. abort has priority over upd_ack in the same cycle.
- start while busy is ignored, including in the DONE cycle.
- err_tol=0 never converges and always ends in timeout.
- iter_count cannot overflow, because termination occurs at max_iter <= 2^ITER_W-1.
- Latency:
  - start to first upd_req = 1 cycle.
  - Each iteration = (cycles waiting in REQ) + 1 CHECK; minimum 2 cycles with zero-wait ack.
  - Last CHECK to done = 1 cycle.

Test Plan:
- Basic convergence (CONSEC=2): init=100, tol=3, max=10; ack zero-wait returning 80, 81, 82 → deltas 20, 1, 1. Required: done pulse, converged=1, timeout=0, result=82, iter_count=3, delta=1, done 7 cycles after the start cycle.
- Timeout: init=0, tol=3, max=4; returns alternate 255, 0, 255, 0 → timeout=1, converged=0, iter_count=4, delta=255, result=0.
- Abs/no-wrap: old=5, new=250 → delta=245. old=250, new=5 → delta=245. tol=246 → counts toward convergence.
- Priority and streak reset (CONSEC=2, max=3): returns give deltas 1, 1 → converge at iter 2. Separate run: deltas 1, 9, 1 with max=3 → timeout at iter 3, not converged. Separate run with max=2 and deltas 1, 1 → converged=1, timeout=0.
- Handshake stalls: upd_ack delayed 5 cycles. upd_req and upd_old must stay stable throughout; upd_req drops the cycle after ack; a spurious upd_ack in CHECK/IDLE has no effect. start during busy is ignored.
- Abort and reset:
  - abort in REQ with simultaneous upd_ack → IDLE, iter_count not incremented by that ack, no done.
  - rst_n=0 during CHECK → all outputs 0 asynchronously.
  - max_iter=0 → done 1 cycle after start, timeout=1, result=init_val.
